// File: rtl/rv32i_decode_stage_pkg.sv
// rtl/rv32i_decode_stage_pkg.sv - shared types and opcode constants for the RV32I decode stage
package rv32i_package;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    // Decoded payload carried by the output and skid registers.
    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] funct12;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } decode_pkt_t;

endpackage

// File: rtl/rv32i_decode_comb.sv
// rtl/rv32i_decode_comb.sv - combinational RV32I(+M) instruction decoder
module rv32i_decode_comb
    import rv32i_package::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [31:0] i_instruction,
    output decode_pkt_t o_pkt
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opc   = i_instruction[6:0];
    assign w_f3    = i_instruction[14:12];
    assign w_f7    = i_instruction[31:25];
    assign w_rs1   = i_instruction[19:15];
    assign w_rs2   = i_instruction[24:20];
    assign w_rd    = i_instruction[11:7];
    assign w_imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
    assign w_imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign w_imm_b = {{20{i_instruction[31]}}, i_instruction[7], i_instruction[30:25],
                      i_instruction[11:8], 1'b0};
    assign w_imm_u = {i_instruction[31:12], 12'h000};
    assign w_imm_j = {{12{i_instruction[31]}}, i_instruction[19:12], i_instruction[20],
                      i_instruction[30:21], 1'b0};

    logic        w_bad;
    decode_pkt_t w_pkt;

    // Per-opcode field selection and legality; unused fields stay zero.
    always_comb begin
        w_pkt        = '0;
        w_bad        = 1'b0;
        w_pkt.opcode = w_opc;
        case (w_opc)
            OPC_OP: begin
                w_pkt.fmt    = FMT_R;
                w_pkt.rd     = w_rd;
                w_pkt.rs1    = w_rs1;
                w_pkt.rs2    = w_rs2;
                w_pkt.funct3 = w_f3;
                w_pkt.funct7 = w_f7;
                w_bad = !((w_f7 == 7'b0000000) ||
                          (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) ||
                          (w_f7 == 7'b0000001 && ENABLE_M != 0));
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
                w_pkt.fmt    = FMT_I;
                w_pkt.rd     = w_rd;
                w_pkt.rs1    = w_rs1;
                w_pkt.funct3 = w_f3;
                w_pkt.imm    = w_imm_i;
                if (w_opc == OPC_SYSTEM) begin
                    w_pkt.funct12 = i_instruction[31:20];
                end
                if (w_opc == OPC_OP_IMM && w_f3 == 3'b001) begin
                    w_bad = (w_f7 != 7'b0000000);
                end else if (w_opc == OPC_OP_IMM && w_f3 == 3'b101) begin
                    w_bad = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                end else if (w_opc == OPC_LOAD) begin
                    w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
                end else if (w_opc == OPC_JALR) begin
                    w_bad = (w_f3 != 3'b000);
                end
            end
            OPC_STORE: begin
                w_pkt.fmt    = FMT_S;
                w_pkt.rs1    = w_rs1;
                w_pkt.rs2    = w_rs2;
                w_pkt.funct3 = w_f3;
                w_pkt.imm    = w_imm_s;
                w_bad        = w_f3[2] || (w_f3[1] && w_f3[0]);
            end
            OPC_BRANCH: begin
                w_pkt.fmt    = FMT_B;
                w_pkt.rs1    = w_rs1;
                w_pkt.rs2    = w_rs2;
                w_pkt.funct3 = w_f3;
                w_pkt.imm    = w_imm_b;
                w_bad        = (w_f3[2:1] == 2'b01);
            end
            OPC_LUI, OPC_AUIPC: begin
                w_pkt.fmt = FMT_U;
                w_pkt.rd  = w_rd;
                w_pkt.imm = w_imm_u;
            end
            OPC_JAL: begin
                w_pkt.fmt = FMT_J;
                w_pkt.rd  = w_rd;
                w_pkt.imm = w_imm_j;
            end
            // Every known opcode ends in 2'b11, so this also catches compressed encodings.
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_pkt         = '0;
            w_pkt.fmt     = FMT_ILL;
            w_pkt.illegal = 1'b1;
        end
    end

    assign o_pkt = w_pkt;

endmodule

// File: rtl/rv32i_decode_stage.sv
// rtl/rv32i_decode_stage.sv - registered valid/ready RV32I decode stage with optional skid entry
module rv32i_decode_stage
    import rv32i_package::*;
#(
    parameter int ENABLE_M    = 1,
    parameter int SKID_BUFFER = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_instruction,
    input  logic [31:0]      fetch_pc,
    output logic             decode_valid,
    input  logic             decode_ready,
    output logic [31:0]      decode_pc,
    output fmt_e             decode_fmt,
    output logic [6:0]       decode_opcode,
    output logic [2:0]       decode_funct3,
    output logic [6:0]       decode_funct7,
    output logic [11:0]      decode_funct12,
    output logic [4:0]       decode_rs1_address,
    output logic [4:0]       decode_rs2_address,
    output logic [4:0]       decode_rd_address,
    output logic [31:0]      decode_imm,
    output logic             decode_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    decode_pkt_t      w_dec;
    logic             w_fetch_ready;
    logic             w_accept;
    logic             w_out_free;

    logic             r_out_valid;
    decode_pkt_t      r_out_pkt;
    logic [31:0]      r_out_pc;
    logic             r_skid_valid;
    decode_pkt_t      r_skid_pkt;
    logic [31:0]      r_skid_pc;
    logic [CNT_W-1:0] r_cnt;

    rv32i_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode_comb (
        .i_instruction (fetch_instruction),
        .o_pkt         (w_dec)
    );

    // With the skid entry, readiness depends only on a flop; without it, on downstream ready.
    assign w_fetch_ready = (SKID_BUFFER != 0) ? !r_skid_valid : (!r_out_valid || decode_ready);
    assign w_accept      = fetch_valid && w_fetch_ready && !flush;
    assign w_out_free    = !r_out_valid || decode_ready;

    // Output and skid registers: flush wins, then refill output from skid (oldest) or input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_pkt    <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pkt   <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // fetch_ready was low, so no new instruction can arrive this cycle.
                r_out_valid  <= 1'b1;
                r_out_pkt    <= r_skid_pkt;
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_pkt   <= w_dec;
                r_out_pc    <= fetch_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept && SKID_BUFFER != 0) begin
            r_skid_valid <= 1'b1;
            r_skid_pkt   <= w_dec;
            r_skid_pc    <= fetch_pc;
        end
    end

    // Saturating count of illegal instructions actually accepted (flushed ones excluded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && w_dec.illegal && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign fetch_ready        = w_fetch_ready;
    assign decode_valid       = r_out_valid;
    assign decode_pc          = r_out_pc;
    assign decode_fmt         = r_out_pkt.fmt;
    assign decode_opcode      = r_out_pkt.opcode;
    assign decode_funct3      = r_out_pkt.funct3;
    assign decode_funct7      = r_out_pkt.funct7;
    assign decode_funct12     = r_out_pkt.funct12;
    assign decode_rs1_address = r_out_pkt.rs1;
    assign decode_rs2_address = r_out_pkt.rs2;
    assign decode_rd_address  = r_out_pkt.rd;
    assign decode_imm         = r_out_pkt.imm;
    assign decode_illegal     = r_out_pkt.illegal;
    assign illegal_count      = r_cnt;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb/tb_rv32i_decode_stage.sv - self-checking bench for rv32i_decode_stage (two configurations)
module tb_rv32i_decode_stage;
    import rv32i_package::*;

    localparam int CW_A = 4;
    localparam int CW_B = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic        decode_ready;

    // Instance A: ENABLE_M=0, skid buffer, narrow counter. Instance B: ENABLE_M=1, no skid.
    logic            rdy_a, val_a, ill_a, rdy_b, val_b, ill_b;
    logic [31:0]     pc_a, imm_a, pc_b, imm_b;
    fmt_e            fmt_a, fmt_b;
    logic [6:0]      opc_a, f7_a, opc_b, f7_b;
    logic [2:0]      f3_a, f3_b;
    logic [11:0]     f12_a, f12_b;
    logic [4:0]      rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;

    rv32i_decode_stage #(.ENABLE_M(0), .SKID_BUFFER(1), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(rdy_a),
        .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
        .decode_valid(val_a), .decode_ready(decode_ready), .decode_pc(pc_a),
        .decode_fmt(fmt_a), .decode_opcode(opc_a), .decode_funct3(f3_a),
        .decode_funct7(f7_a), .decode_funct12(f12_a),
        .decode_rs1_address(rs1_a), .decode_rs2_address(rs2_a), .decode_rd_address(rd_a),
        .decode_imm(imm_a), .decode_illegal(ill_a), .illegal_count(cnt_a)
    );

    rv32i_decode_stage #(.ENABLE_M(1), .SKID_BUFFER(0), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(rdy_b),
        .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
        .decode_valid(val_b), .decode_ready(decode_ready), .decode_pc(pc_b),
        .decode_fmt(fmt_b), .decode_opcode(opc_b), .decode_funct3(f3_b),
        .decode_funct7(f7_b), .decode_funct12(f12_b),
        .decode_rs1_address(rs1_b), .decode_rs2_address(rs2_b), .decode_rd_address(rd_b),
        .decode_imm(imm_b), .decode_illegal(ill_b), .illegal_count(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] f12;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } ref_t;

    int total = 0;
    int bad   = 0;

    // Reference model: a FIFO of {pc, instruction} per instance plus an integer counter.
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    int          mc_a = 0;
    int          mc_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decode written straight from the ISA tables, independent of the RTL structure.
    function automatic ref_t ref_decode(input logic [31:0] ins, input bit en_m);
        ref_t r;
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        int opc;
        int f3;
        int f7;
        bit ok;
        r   = '0;
        opc = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        ok  = 1'b1;
        case (opc)
            'h33: begin
                r.fmt = 3'd0;
                ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && en_m);
            end
            'h13: begin
                r.fmt = 3'd1;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0) || (f7 == 'h20);
            end
            'h03: begin r.fmt = 3'd1; ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); end
            'h67: begin r.fmt = 3'd1; ok = (f3 == 0); end
            'h73, 'h0F: r.fmt = 3'd1;
            'h23: begin r.fmt = 3'd2; ok = (f3 <= 2); end
            'h63: begin r.fmt = 3'd3; ok = !(f3 == 2 || f3 == 3); end
            'h37, 'h17: r.fmt = 3'd4;
            'h6F: r.fmt = 3'd5;
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            r     = '0;
            r.fmt = 3'd6;
            r.ill = 1'b1;
            return r;
        end
        r.opc = ins[6:0];
        if (r.fmt != 3'd2 && r.fmt != 3'd3) r.rd = ins[11:7];
        if (r.fmt <= 3'd3) begin
            r.f3  = ins[14:12];
            r.rs1 = ins[19:15];
        end
        if (r.fmt == 3'd0 || r.fmt == 3'd2 || r.fmt == 3'd3) r.rs2 = ins[24:20];
        if (r.fmt == 3'd0) r.f7 = ins[31:25];
        if (opc == 'h73) r.f12 = ins[31:20];
        case (r.fmt)
            3'd1: begin s12 = ins[31:20]; r.imm = 32'(s12); end
            3'd2: begin s12 = {ins[31:25], ins[11:7]}; r.imm = 32'(s12); end
            3'd3: begin s13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; r.imm = 32'(s13); end
            3'd4: r.imm = ins[31:12] * 32'd4096;
            3'd5: begin s21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; r.imm = 32'(s21); end
            default: r.imm = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check_outputs();
        ref_t e;
        chk("valid_a", 32'(val_a), 32'(q_a.size() > 0));
        chk("valid_b", 32'(val_b), 32'(q_b.size() > 0));
        chk("count_a", 32'(cnt_a), mc_a);
        chk("count_b", 32'(cnt_b), mc_b);
        if (q_a.size() > 0) begin
            e = ref_decode(q_a[0][31:0], 1'b0);
            chk("pc_a", pc_a, q_a[0][63:32]);
            chk("fmt_a", 32'(fmt_a), 32'(e.fmt));
            chk("imm_a", imm_a, e.imm);
            chk("func_a", {3'b0, opc_a, f3_a, f7_a, f12_a}, {3'b0, e.opc, e.f3, e.f7, e.f12});
            chk("regs_a", {16'b0, rs1_a, rs2_a, rd_a, ill_a}, {16'b0, e.rs1, e.rs2, e.rd, e.ill});
        end
        if (q_b.size() > 0) begin
            e = ref_decode(q_b[0][31:0], 1'b1);
            chk("pc_b", pc_b, q_b[0][63:32]);
            chk("fmt_b", 32'(fmt_b), 32'(e.fmt));
            chk("imm_b", imm_b, e.imm);
            chk("func_b", {3'b0, opc_b, f3_b, f7_b, f12_b}, {3'b0, e.opc, e.f3, e.f7, e.f12});
            chk("regs_b", {16'b0, rs1_b, rs2_b, rd_b, ill_b}, {16'b0, e.rs1, e.rs2, e.rd, e.ill});
        end
    endtask

    // One clock: drive at the falling edge, check ready, advance the model, check outputs.
    task automatic cycle(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic dr, input logic fl);
        bit er_a;
        bit er_b;
        bit acc_a;
        bit acc_b;
        fetch_valid       = fv;
        fetch_instruction = ins;
        fetch_pc          = pc;
        decode_ready      = dr;
        flush             = fl;
        #1;
        er_a = (q_a.size() < 2);
        er_b = (q_b.size() == 0) || dr;
        chk("ready_a", 32'(rdy_a), 32'(er_a));
        chk("ready_b", 32'(rdy_b), 32'(er_b));
        acc_a = fv && er_a && !fl;
        acc_b = fv && er_b && !fl;
        @(posedge clk);
        if (fl) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (q_a.size() > 0 && dr) void'(q_a.pop_front());
            if (q_b.size() > 0 && dr) void'(q_b.pop_front());
            if (acc_a) q_a.push_back({pc, ins});
            if (acc_b) q_b.push_back({pc, ins});
        end
        if (acc_a && ref_decode(ins, 1'b0).ill && mc_a < (1 << CW_A) - 1) mc_a++;
        if (acc_b && ref_decode(ins, 1'b1).ill && mc_b < (1 << CW_B) - 1) mc_b++;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs[11];
        int          k;
        int          s;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        w = $urandom;
        k = $urandom_range(0, 13);
        if (k < 11) w[6:0] = opcs[k];
        s = $urandom_range(0, 3);
        if (s == 0) w[31:25] = 7'h00;
        if (s == 1) w[31:25] = 7'h20;
        if (s == 2) w[31:25] = 7'h01;
        return w;
    endfunction

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        mc_a = 0;
        mc_b = 0;
        chk({tag, "_valid_a"}, 32'(val_a), 32'd0);
        chk({tag, "_valid_b"}, 32'(val_b), 32'd0);
        chk({tag, "_count_a"}, 32'(cnt_a), 32'd0);
        chk({tag, "_count_b"}, 32'(cnt_b), 32'd0);
        chk({tag, "_ready_a"}, 32'(rdy_a), 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        rst_n             = 1'b0;
        flush             = 1'b0;
        fetch_valid       = 1'b0;
        fetch_instruction = 32'h0;
        fetch_pc          = 32'h0;
        decode_ready      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid_a", 32'(val_a), 32'd0);
        chk("rst_fmt_a", 32'(fmt_a), 32'd0);
        chk("rst_imm_a", imm_a, 32'd0);
        chk("rst_pc_b", pc_b, 32'd0);
        chk("rst_ready_a", 32'(rdy_a), 32'd1);
        chk("rst_ready_b", 32'(rdy_b), 32'd1);
        chk("rst_count_a", 32'(cnt_a), 32'd0);
        rst_n = 1'b1;

        // ADDI x1,x0,-1
        cycle(1'b1, 32'hFFF00093, 32'h0000_1000, 1'b1, 1'b0);
        chk("addi_imm", imm_a, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(rd_a), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // JAL, BEQ, SW streamed back to back
        cycle(1'b1, 32'hFFDFF06F, 32'h0000_2000, 1'b1, 1'b0);
        chk("jal_imm", imm_b, 32'hFFFF_FFFC);
        cycle(1'b1, 32'hFE208CE3, 32'h0000_2004, 1'b1, 1'b0);
        chk("beq_imm", imm_b, 32'hFFFF_FFF8);
        cycle(1'b1, 32'hFE20AE23, 32'h0000_2008, 1'b1, 1'b0);
        chk("sw_imm", imm_b, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // MUL: illegal without M, legal R-type with M
        cycle(1'b1, 32'h022081B3, 32'h0000_3000, 1'b1, 1'b0);
        chk("mul_ill_a", 32'(ill_a), 32'd1);
        chk("mul_fmt_b", 32'(fmt_b), 32'(FMT_R));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall with three offers: skid instance takes two, then deasserts ready
        cycle(1'b1, 32'h00108113, 32'h0000_4000, 1'b0, 1'b0);
        cycle(1'b1, 32'h00210193, 32'h0000_4004, 1'b0, 1'b0);
        cycle(1'b1, 32'h00318213, 32'h0000_4008, 1'b0, 1'b0);
        chk("skid_ready_low", 32'(rdy_a), 32'd0);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with output and skid full and an illegal word offered
        cycle(1'b1, 32'h00108113, 32'h0000_5000, 1'b0, 1'b0);
        cycle(1'b1, 32'h00210193, 32'h0000_5004, 1'b0, 1'b0);
        cycle(1'b1, 32'h00000000, 32'h0000_5008, 1'b0, 1'b1);
        chk("flush_ready_a", 32'(rdy_a), 32'd1);
        chk("flush_valid_a", 32'(val_a), 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            w = rand_instr();
            cycle(1'($urandom_range(0, 3) != 0), w, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        async_reset_check("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 2^CW_A + 3 illegal words into the narrow counter
        for (int i = 0; i < (1 << CW_A) + 3; i++) begin
            cycle(1'b1, 32'h0000_0000, 32'(i * 4), 1'b1, 1'b0);
        end
        chk("sat_count_a", 32'(cnt_a), 32'(15));
        chk("sat_count_b", 32'(cnt_b), 32'(19));
        cycle(1'b1, 32'h0000_0000, 32'h0000_6000, 1'b1, 1'b0);
        #2;
        async_reset_check("rst_stream");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
